// File: rtl/aes128_key_schedule_if.sv
// ============================================================================
// Module      : aes128_key_schedule_if
// Description : Start/key request and round-key handshake bundle for the
//               AES-128 key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes128_key_schedule_if;
    logic         start_i;
    logic [127:0] key_i;
    logic         rkey_ready_i;
    logic [127:0] rkey_o;
    logic         rkey_valid_o;
    logic [3:0]   round_o;
    logic         busy_o;
    logic         done_o;

    modport master (
        output start_i,
        output key_i,
        output rkey_ready_i,
        input  rkey_o,
        input  rkey_valid_o,
        input  round_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  start_i,
        input  key_i,
        input  rkey_ready_i,
        output rkey_o,
        output rkey_valid_o,
        output round_o,
        output busy_o,
        output done_o
    );
endinterface

`default_nettype wire

// File: rtl/aes128_key_schedule.sv
// ============================================================================
// Module      : aes128_key_schedule
// Description : Iterative AES-128 key expansion; emits round keys 0..10, one
//               per valid/ready handshake, from a registered key word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_key_schedule #(
    parameter bit ZERO_WHEN_IDLE = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_n,
    aes128_key_schedule_if.slave        bus
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_RUN        = 2'd1;
    localparam logic [1:0] S_DONE       = 2'd2;
    localparam logic [3:0] C_LAST_ROUND = 4'd10;
    localparam logic [7:0] C_RCON_INIT  = 8'h01;

    // GF(2^8) arithmetic over x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q,   key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q,  rcon_d;

    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;
    logic         w_valid;
    logic         w_xfer;

    // Next key is purely combinational from key_q and rcon_q.
    assign w_rot = {key_q[23:0], key_q[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
        end
    endgenerate

    assign w_t        = w_sub ^ {rcon_q, 24'h000000};
    assign w_n0       = key_q[127:96] ^ w_t;
    assign w_n1       = key_q[95:64]  ^ w_n0;
    assign w_n2       = key_q[63:32]  ^ w_n1;
    assign w_n3       = key_q[31:0]   ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    assign w_valid = (state_q == S_RUN);
    assign w_xfer  = w_valid && bus.rkey_ready_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= C_RCON_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_RUN;
                    key_d   = bus.key_i;
                    round_d = 4'd0;
                    rcon_d  = C_RCON_INIT;
                end
            end
            S_RUN: begin
                // The last key stays in key_q so it can be held after DONE.
                if (w_xfer) begin
                    if (round_q == C_LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        key_d   = w_next_key;
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                round_d = 4'd0;
                rcon_d  = C_RCON_INIT;
            end
        endcase
    end

    always_comb begin
        bus.rkey_valid_o = w_valid;
        bus.round_o      = round_q;
        bus.busy_o       = (state_q == S_RUN) || (state_q == S_DONE);
        bus.done_o       = (state_q == S_DONE);
        bus.rkey_o       = key_q;
        if (ZERO_WHEN_IDLE && !w_valid) begin
            bus.rkey_o = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes128_key_schedule.sv
// ============================================================================
// Module      : tb_aes128_key_schedule
// Description : Self-checking bench: FIPS-197 vectors, backpressure, ignored
//               start, async reset abort, back-to-back and idle-zeroing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes128_key_schedule;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes128_key_schedule_if if0 ();
    aes128_key_schedule_if if1 ();

    assign if1.start_i      = if0.start_i;
    assign if1.key_i        = if0.key_i;
    assign if1.rkey_ready_i = if0.rkey_ready_i;

    aes128_key_schedule #(.ZERO_WHEN_IDLE(1'b1)) dut0 (.clk_i(clk), .rst_n(rst_n), .bus(if0));
    aes128_key_schedule #(.ZERO_WHEN_IDLE(1'b0)) dut1 (.clk_i(clk), .rst_n(rst_n), .bus(if1));

    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    exp_t         tbl_a1 [11];
    logic [127:0] a1_keys [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    exp_t sb_q [$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // Scoreboard monitor and stall-stability checker.
    initial begin
        logic [127:0] prev_key;
        logic [3:0]   prev_rnd;
        bit           prev_stall;
        exp_t         e;
        prev_key   = '0;
        prev_rnd   = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_key", if0.rkey_o, prev_key);
                    check("stall_round", 128'(if0.round_o), 128'(prev_rnd));
                end
                if (if0.rkey_valid_o && if0.rkey_ready_i) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected actual=round%0d required=none", if0.round_o);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_round", 128'(if0.round_o), 128'(e.rnd));
                        if (e.chk) check("sb_key", if0.rkey_o, e.key);
                        check("sb_key_p0", if1.rkey_o, if0.rkey_o);
                    end
                end
                if (!if0.rkey_valid_o) check("zero_when_idle", if0.rkey_o, 128'h0);
                if (if0.done_o) done_cnt++;
                prev_stall = if0.rkey_valid_o && !if0.rkey_ready_i;
                prev_key   = if0.rkey_o;
                prev_rnd   = if0.round_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a1();
        for (int i = 0; i < 11; i++) sb_q.push_back(tbl_a1[i]);
    endtask

    task automatic start_exp(input logic [127:0] k);
        if0.key_i   = k;
        if0.start_i = 1'b1;
        tick();
        if0.start_i = 1'b0;
        if0.key_i   = ~k;
        check("lat_valid", 128'(if0.rkey_valid_o), 128'd1);
        check("lat_round", 128'(if0.round_o), 128'd0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (if0.done_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (if0.done_o !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout_done actual=%0d required=done", n);
        end
    endtask

    task automatic wait_round(input logic [3:0] r, input int budget);
        int n = 0;
        while (!(if0.rkey_valid_o === 1'b1 && if0.round_o === r) && n < budget) begin
            tick();
            n++;
        end
        if (!(if0.rkey_valid_o === 1'b1 && if0.round_o === r)) begin
            total++;
            bad++;
            $display("FAIL timeout_round actual=%0d required=%0d", if0.round_o, r);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rkey0"}, if0.rkey_o, 128'h0);
        check({tag, "_rkey1"}, if1.rkey_o, 128'h0);
        check({tag, "_valid"}, 128'({if0.rkey_valid_o, if1.rkey_valid_o}), 128'd0);
        check({tag, "_round"}, 128'({if0.round_o, if1.round_o}), 128'd0);
        check({tag, "_busy"},  128'({if0.busy_o, if1.busy_o}), 128'd0);
        check({tag, "_done"},  128'({if0.done_o, if1.done_o}), 128'd0);
    endtask

    initial begin
        int   stall;
        int   n;
        int   done_before;
        exp_t e;

        for (int i = 0; i < 11; i++) tbl_a1[i] = '{4'(i), a1_keys[i], 1'b1};

        if0.start_i      = 1'b0;
        if0.key_i        = '0;
        if0.rkey_ready_i = 1'b0;
        #2;
        check_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 A.1 at full throughput
        if0.rkey_ready_i = 1'b1;
        push_a1();
        start_exp(KEY_A1);
        for (int i = 0; i < 11; i++) begin
            check("a1_valid_run", 128'(if0.rkey_valid_o), 128'd1);
            tick();
        end
        check("a1_done", 128'(if0.done_o), 128'd1);
        check("a1_done_valid", 128'(if0.rkey_valid_o), 128'd0);
        check("a1_done_busy", 128'(if0.busy_o), 128'd1);
        check("a1_done_round", 128'(if0.round_o), 128'd10);
        check("a1_hold_p0", if1.rkey_o, a1_keys[10]);
        tick();
        check("a1_idle_busy", 128'(if0.busy_o), 128'd0);
        check("a1_idle_done", 128'(if0.done_o), 128'd0);
        check("a1_idle_round", 128'(if0.round_o), 128'd0);
        check("a1_idle_hold_p0", if1.rkey_o, a1_keys[10]);
        check("a1_drained", 128'(sb_q.size()), 128'd0);

        // Random backpressure with a 5-cycle stall at round 4
        if0.rkey_ready_i = 1'b0;
        push_a1();
        start_exp(KEY_A1);
        stall = 0;
        n     = 0;
        while (if0.done_o !== 1'b1 && n < 400) begin
            if (if0.rkey_valid_o && if0.round_o == 4'd4 && stall < 5) begin
                if0.rkey_ready_i = 1'b0;
                stall++;
            end else begin
                if0.rkey_ready_i = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        check("bp_done", 128'(if0.done_o), 128'd1);
        check("bp_stall_len", 128'(stall), 128'd5);
        tick();
        check("bp_drained", 128'(sb_q.size()), 128'd0);

        // start_i pulse mid-run must be ignored
        if0.rkey_ready_i = 1'b1;
        push_a1();
        start_exp(KEY_A1);
        wait_round(4'd3, 20);
        if0.start_i = 1'b1;
        if0.key_i   = '1;
        tick();
        if0.start_i = 1'b0;
        wait_done(20);
        tick();
        check("ign_drained", 128'(sb_q.size()), 128'd0);
        check("ign_idle", 128'(if0.busy_o), 128'd0);

        // Async reset during round 6 aborts without done
        push_a1();
        start_exp(KEY_A1);
        wait_round(4'd6, 20);
        done_before = done_cnt;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        sb_q.delete();
        tick();
        tick();
        check("abort_no_done", 128'(done_cnt), 128'(done_before));
        rst_n = 1'b1;
        tick();
        sb_q.push_back('{4'd0, 128'h0, 1'b1});
        sb_q.push_back('{4'd1, 128'h62636363626363636263636362636363, 1'b1});
        for (int i = 2; i < 11; i++) sb_q.push_back('{4'(i), 128'h0, 1'b0});
        start_exp(128'h0);
        wait_done(20);
        tick();
        check("zero_drained", 128'(sb_q.size()), 128'd0);

        // Back-to-back with start held high
        push_a1();
        push_a1();
        if0.key_i   = KEY_A1;
        if0.start_i = 1'b1;
        tick();
        wait_done(20);
        tick();
        check("b2b_idle_gap", 128'(if0.busy_o), 128'd0);
        tick();
        check("b2b_restart_busy", 128'(if0.busy_o), 128'd1);
        check("b2b_restart_round", 128'(if0.round_o), 128'd0);
        check("b2b_restart_key", if0.rkey_o, KEY_A1);
        if0.start_i = 1'b0;
        wait_done(20);
        tick();
        check("b2b_drained", 128'(sb_q.size()), 128'd0);
        check("b2b_hold_p0", if1.rkey_o, a1_keys[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
